branch_resolve_unit: RTL and testbench

- EX-stage consumer of the branch condition bit `y` produced by the condition evaluator.
- Decides taken/not-taken for conditional branches and unconditional jumps, and computes the target PC.
- Drives a registered redirect handshake to fetch, flushes wrong-path instructions in IF/ID and ID/EX, and keeps saturating branch statistics.

---
 rtl/kgp_branch_pkg.sv | 16 +
 rtl/sat_counter.sv | 30 +++
 rtl/branch_resolve_unit.sv | 122 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_branch_pkg.sv
// Shared types and constants for the branch resolve unit.
//   state_e       : redirect FSM state encoding
//   PC_INC        : byte distance to the sequential instruction
//   CNT_W_DEFAULT : default width of the branch statistics counters
package kgp_branch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRedirect,
    StFlush
  } state_e;

  localparam int unsigned PC_INC        = 4;
  localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : add one, holding at all-ones
//   cnt        : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: decides taken/not-taken, computes the target, drives a
// registered redirect handshake to fetch, flushes wrong-path stages and counts branches.
//   ex_*            : EX-stage instruction and its condition bit
//   redirect_ready  : fetch accepts the redirect
//   cnt_clr         : synchronous clear of the statistics counters
//   redirect_valid  : redirect pending (redirect_pc stable while high)
//   flush_if_id/ex  : squash IF/ID and ID/EX
//   ex_stall        : hold EX and earlier while the redirect is pending
//   branch_cnt      : resolved branches and jumps, saturating
//   taken_cnt       : taken branches and jumps, saturating
module branch_resolve_unit
  import kgp_branch_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_is_jump,
  input  logic              ex_cond,
  input  logic              ex_use_reg,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_offset,
  input  logic [ADDR_W-1:0] ex_reg_target,
  input  logic              redirect_ready,
  input  logic              cnt_clr,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              ex_stall,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_e            state_q, state_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              resolve, taken, in_idle;
  logic [ADDR_W-1:0] target;

  // A jump wins over the condition when both type bits are set.
  assign resolve = ex_valid & (ex_is_branch | ex_is_jump);
  assign taken   = ex_valid & (ex_is_jump | (ex_is_branch & ex_cond));
  assign target  = ex_use_reg ? ex_reg_target : (ex_pc + ADDR_W'(PC_INC) + ex_offset);
  assign in_idle = (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_d        = pc_q;
    case (state_q)
      StIdle: begin
        if (taken) begin
          pc_d    = target;
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        if (redirect_valid && redirect_ready) begin
          flush_cnt_d = 3'(FLUSH_DEPTH);
          state_d     = StFlush;
        end
      end
      StFlush: begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_d == 3'd0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered copies decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      flush_cnt_q    <= 3'd0;
      pc_q           <= '0;
      redirect_valid <= 1'b0;
      flush_if_id    <= 1'b0;
      flush_id_ex    <= 1'b0;
      ex_stall       <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      pc_q           <= pc_d;
      redirect_valid <= (state_d == StRedirect);
      flush_if_id    <= (state_d != StIdle);
      flush_id_ex    <= (state_d != StIdle);
      ex_stall       <= (state_d == StRedirect);
    end
  end

  assign redirect_pc = pc_q;

  // Wrong-path instructions (outside IDLE) are not counted.
  sat_counter #(
    .W (CNT_W)
  ) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (in_idle & resolve),
    .cnt   (branch_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (in_idle & taken),
    .cnt   (taken_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0;
  logic          ex_cond = 1'b0, ex_use_reg = 1'b0;
  logic [AW-1:0] ex_pc = '0, ex_offset = '0, ex_reg_target = '0;
  logic          redirect_ready = 1'b0, cnt_clr = 1'b0;
  logic          redirect_valid, flush_if_id, flush_id_ex, ex_stall;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] branch_cnt, taken_cnt;

  branch_resolve_unit #(
    .ADDR_W      (AW),
    .FLUSH_DEPTH (2),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_cond        (ex_cond),
    .ex_use_reg     (ex_use_reg),
    .ex_pc          (ex_pc),
    .ex_offset      (ex_offset),
    .ex_reg_target  (ex_reg_target),
    .redirect_ready (redirect_ready),
    .cnt_clr        (cnt_clr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .ex_stall       (ex_stall),
    .branch_cnt     (branch_cnt),
    .taken_cnt      (taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          br, jmp, cond, use_reg, valid;
    logic [AW-1:0] pc, off, rt;
    logic          exp_resolve, exp_taken;
    logic [AW-1:0] exp_pc;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic j, input logic c,
                       input logic u, input logic [AW-1:0] pc, input logic [AW-1:0] off,
                       input logic [AW-1:0] rt);
    ex_valid = v; ex_is_branch = b; ex_is_jump = j; ex_cond = c; ex_use_reg = u;
    ex_pc = pc; ex_offset = off; ex_reg_target = rt;
  endtask

  task automatic idle_ex();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic chk_outs(input string tag, input logic rv, input logic fl, input logic st);
    chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
    chk({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fl});
    chk({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, fl});
    chk({tag, ".ex_stall"}, {31'd0, ex_stall}, {31'd0, st});
  endtask

  function automatic vec_t mk(input string n, input logic v, input logic b, input logic j,
                              input logic c, input logic u, input logic [AW-1:0] pc,
                              input logic [AW-1:0] off, input logic [AW-1:0] rt,
                              input logic er, input logic et, input logic [AW-1:0] ep);
    vec_t r;
    r.name = n; r.valid = v; r.br = b; r.jmp = j; r.cond = c; r.use_reg = u;
    r.pc = pc; r.off = off; r.rt = rt; r.exp_resolve = er; r.exp_taken = et; r.exp_pc = ep;
    return r;
  endfunction

  vec_t vecs[9];
  int   exp_b, exp_t, k;

  initial begin
    vecs[0] = mk("not_taken", 1, 1, 0, 0, 0, 32'h100, 32'h40, 0, 1, 0, 32'h0);
    vecs[1] = mk("taken_rel", 1, 1, 0, 1, 0, 32'h100, 32'hFFFF_FFF0, 0, 1, 1, 32'hF4);
    vecs[2] = mk("wrap", 1, 1, 0, 1, 0, 32'hFFFF_FFF8, 32'h8, 0, 1, 1, 32'h4);
    vecs[3] = mk("br_and_jmp", 1, 1, 1, 0, 0, 32'h40, 32'h10, 0, 1, 1, 32'h54);
    vecs[4] = mk("jr", 1, 0, 1, 0, 1, 32'h80, 32'h0, 32'h2000, 1, 1, 32'h2000);
    vecs[5] = mk("invalid_jmp", 0, 0, 1, 1, 0, 32'h200, 32'h20, 0, 0, 0, 32'h0);
    vecs[6] = mk("non_branch", 1, 0, 0, 1, 0, 32'h300, 32'h20, 0, 0, 0, 32'h0);
    vecs[7] = mk("br_reg", 1, 1, 0, 1, 1, 32'h400, 32'h0, 32'h1234_5678, 1, 1,
                 32'h1234_5678);
    vecs[8] = mk("jmp_rel0", 1, 0, 1, 0, 0, 32'h1000, 32'h0, 0, 1, 1, 32'h1004);

    // Reset state
    step();
    chk_outs("reset", 0, 0, 0);
    chk("reset.redirect_pc", redirect_pc, 32'h0);
    chk("reset.branch_cnt", {28'd0, branch_cnt}, 32'h0);
    chk("reset.taken_cnt", {28'd0, taken_cnt}, 32'h0);
    rst_n = 1'b1;
    redirect_ready = 1'b1;
    step();

    // Table-driven single transactions, ready tied high
    exp_b = 0;
    exp_t = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].br, vecs[i].jmp, vecs[i].cond, vecs[i].use_reg,
            vecs[i].pc, vecs[i].off, vecs[i].rt);
      step();
      idle_ex();
      exp_b += int'(vecs[i].exp_resolve);
      exp_t += int'(vecs[i].exp_taken);
      if (vecs[i].exp_taken) begin
        chk_outs({vecs[i].name, ".t1"}, 1, 1, 1);
        chk({vecs[i].name, ".redirect_pc"}, redirect_pc, vecs[i].exp_pc);
        step();
        chk_outs({vecs[i].name, ".t2"}, 0, 1, 0);
        step();
        chk_outs({vecs[i].name, ".t3"}, 0, 1, 0);
        step();
        chk_outs({vecs[i].name, ".t4"}, 0, 0, 0);
      end else begin
        chk_outs({vecs[i].name, ".t1"}, 0, 0, 0);
      end
      chk({vecs[i].name, ".branch_cnt"}, {28'd0, branch_cnt}, 32'(exp_b));
      chk({vecs[i].name, ".taken_cnt"}, {28'd0, taken_cnt}, 32'(exp_t));
    end

    // Register jump with back-pressure; a wrong-path taken branch is ignored
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("bp.clr_branch_cnt", {28'd0, branch_cnt}, 32'h0);
    redirect_ready = 1'b0;
    drive(1, 0, 1, 0, 1, 32'h80, 32'h0, 32'h2000);
    step();
    chk_outs("bp.t1", 1, 1, 1);
    chk("bp.t1.redirect_pc", redirect_pc, 32'h2000);
    drive(1, 1, 0, 1, 0, 32'h500, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      idle_ex();
      chk_outs($sformatf("bp.wait%0d", i), 1, 1, 1);
      chk($sformatf("bp.wait%0d.redirect_pc", i), redirect_pc, 32'h2000);
    end
    redirect_ready = 1'b1;
    step();
    chk_outs("bp.hs", 0, 1, 0);
    step();
    step();
    chk_outs("bp.done", 0, 0, 0);
    chk("bp.branch_cnt", {28'd0, branch_cnt}, 32'h1);
    chk("bp.taken_cnt", {28'd0, taken_cnt}, 32'h1);

    // Reset mid-REDIRECT
    redirect_ready = 1'b0;
    drive(1, 0, 1, 0, 1, 32'h0, 32'h0, 32'h3000);
    step();
    idle_ex();
    chk_outs("rst.pre", 1, 1, 1);
    rst_n = 1'b0;
    #1;
    chk_outs("rst.async", 0, 0, 0);
    chk("rst.async.redirect_pc", redirect_pc, 32'h0);
    chk("rst.async.taken_cnt", {28'd0, taken_cnt}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk_outs("rst.after", 0, 0, 0);
    redirect_ready = 1'b1;
    drive(1, 0, 1, 0, 1, 32'h0, 32'h0, 32'h3000);
    step();
    idle_ex();
    chk_outs("rst.new_redirect", 1, 1, 1);
    chk("rst.new_redirect_pc", redirect_pc, 32'h3000);
    step();
    step();
    step();
    chk_outs("rst.new_done", 0, 0, 0);

    // Saturation with 20 completed taken jumps
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 1, 32'h0, 32'h0, 32'h4000);
      step();
      idle_ex();
      k = 0;
      while ((redirect_valid || flush_if_id) && k < 10) begin
        step();
        k++;
      end
      chk($sformatf("sat.drain%0d", i), 32'(k < 10), 32'h1);
    end
    chk("sat.branch_cnt", {28'd0, branch_cnt}, 32'hF);
    chk("sat.taken_cnt", {28'd0, taken_cnt}, 32'hF);

    // Clear has priority over a same-cycle resolve
    cnt_clr = 1'b1;
    drive(1, 1, 0, 0, 0, 32'h100, 32'h0, 32'h0);
    step();
    cnt_clr = 1'b0;
    idle_ex();
    chk("clr.branch_cnt", {28'd0, branch_cnt}, 32'h0);
    chk("clr.taken_cnt", {28'd0, taken_cnt}, 32'h0);
    chk_outs("clr", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
